// File: rtl/lfsr_gen.sv
// Parametrised Galois/Fibonacci LFSR with seed load, zero-seed substitution and wrap detection.
// Define LFSR_PERIOD_CNT_EN to build the advance counter that reports the sequence period.
module lfsr_gen #(
    parameter int               WIDTH      = 16,
    parameter logic [WIDTH-1:0] TAPS       = 16'hB400,
    parameter int               MODE       = 0,
    parameter int               STEPS      = 1,
    parameter logic [WIDTH-1:0] RESET_SEED = 16'hACE1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    input  logic             en,
    output logic [WIDTH-1:0] state,
    output logic             out_bit,
    output logic             seed_zero,
    output logic             wrap,
    output logic [31:0]      period
);

    if (TAPS == {WIDTH{1'b0}}) begin : g_bad_taps
        $error("lfsr_gen: TAPS must not be all-zero");
    end
    if (RESET_SEED == {WIDTH{1'b0}}) begin : g_bad_seed
        $error("lfsr_gen: RESET_SEED must be non-zero");
    end
    if (WIDTH < 3 || WIDTH > 64) begin : g_bad_width
        $error("lfsr_gen: WIDTH out of range 3..64");
    end
    if (STEPS < 1 || STEPS > WIDTH) begin : g_bad_steps
        $error("lfsr_gen: STEPS out of range 1..WIDTH");
    end

    function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] s);
        logic [WIDTH-1:0] r;
        logic             fb;
        fb = ^(s & TAPS);
        if (MODE == 0) begin
            r = (s >> 1) ^ (s[0] ? TAPS : {WIDTH{1'b0}});
        end else begin
            r = {fb, s[WIDTH-1:1]};
        end
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] s);
        logic [WIDTH-1:0] r;
        r = s;
        for (int i = 0; i < STEPS; i++) begin
            r = shift_once(r);
        end
        return r;
    endfunction

    logic [WIDTH-1:0] state_q, state_d;
    logic [WIDTH-1:0] ref_seed_q, ref_seed_d;
    logic             seed_zero_q, seed_zero_d;
    logic             wrap_q, wrap_d;
    logic [WIDTH-1:0] adv_s;
    logic [WIDTH-1:0] seed_eff_s;
    logic             hit_s;

    // Next-state selection: load beats advance beats hold
    always_comb begin
        adv_s       = advance(state_q);
        seed_eff_s  = (seed == {WIDTH{1'b0}}) ? RESET_SEED : seed;
        hit_s       = 1'b0;
        state_d     = state_q;
        ref_seed_d  = ref_seed_q;
        seed_zero_d = 1'b0;
        wrap_d      = 1'b0;
        if (load) begin
            state_d     = seed_eff_s;
            ref_seed_d  = seed_eff_s;
            seed_zero_d = (seed == {WIDTH{1'b0}});
        end else if (en) begin
            state_d = adv_s;
            hit_s   = (adv_s == ref_seed_q);
            wrap_d  = hit_s;
        end else begin
            state_d = state_q;
        end
    end

    // Core state, reference seed and pulse registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RESET_SEED;
            ref_seed_q  <= RESET_SEED;
            seed_zero_q <= 1'b0;
            wrap_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ref_seed_q  <= ref_seed_d;
            seed_zero_q <= seed_zero_d;
            wrap_q      <= wrap_d;
        end
    end

`ifdef LFSR_PERIOD_CNT_EN
    logic [31:0] adv_cnt_q, adv_cnt_d;
    logic [31:0] period_q, period_d;
    logic [31:0] cnt_inc_s;

    // Advance counter: restarts on load or wrap, latches the period on wrap
    always_comb begin
        cnt_inc_s = (adv_cnt_q == 32'hFFFF_FFFF) ? adv_cnt_q : adv_cnt_q + 32'd1;
        adv_cnt_d = adv_cnt_q;
        period_d  = period_q;
        if (load) begin
            adv_cnt_d = 32'd0;
        end else if (hit_s) begin
            adv_cnt_d = 32'd0;
            period_d  = cnt_inc_s;
        end else if (en) begin
            adv_cnt_d = cnt_inc_s;
        end else begin
            adv_cnt_d = adv_cnt_q;
        end
    end

    // Counter and period registers
    always_ff @(posedge clk) begin
        if (reset) begin
            adv_cnt_q <= 32'd0;
            period_q  <= 32'd0;
        end else begin
            adv_cnt_q <= adv_cnt_d;
            period_q  <= period_d;
        end
    end

    assign period = period_q;
`else
    assign period = 32'd0;
`endif

    assign state     = state_q;
    assign out_bit   = state_q[0];
    assign seed_zero = seed_zero_q;
    assign wrap      = wrap_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// Self-checking bench for lfsr_gen: three configurations (Galois, Fibonacci, Galois STEPS=2)
// driven by shared directed and random stimulus, compared against an arithmetic reference model.
module tb_lfsr_gen;

    logic        clk = 1'b0;
    logic        reset, load, en;
    logic [15:0] seed;

    logic [15:0] st0, st1, st2;
    logic        ob0, ob1, ob2, sz0, sz1, sz2, wr0, wr1, wr2;
    logic [31:0] pr0, pr1, pr2;

    int n_checks = 0;
    int n_fail   = 0;
    int wraps    = 0;

    // reference model, one slot per instance
    logic [15:0] m_st  [3];
    logic [15:0] m_ref [3];
    logic        m_sz  [3];
    logic        m_wr  [3];
    logic [31:0] m_per [3];
    logic [31:0] m_adv [3];
    int          m_mode  [3] = '{0, 1, 0};
    int          m_steps [3] = '{1, 1, 2};

    always #5 clk = ~clk;

    lfsr_gen #(.WIDTH(16), .TAPS(16'hB400), .MODE(0), .STEPS(1), .RESET_SEED(16'hACE1)) dut_gal (
        .clk(clk), .reset(reset), .load(load), .seed(seed), .en(en),
        .state(st0), .out_bit(ob0), .seed_zero(sz0), .wrap(wr0), .period(pr0));
    lfsr_gen #(.WIDTH(16), .TAPS(16'hB400), .MODE(1), .STEPS(1), .RESET_SEED(16'hACE1)) dut_fib (
        .clk(clk), .reset(reset), .load(load), .seed(seed), .en(en),
        .state(st1), .out_bit(ob1), .seed_zero(sz1), .wrap(wr1), .period(pr1));
    lfsr_gen #(.WIDTH(16), .TAPS(16'hB400), .MODE(0), .STEPS(2), .RESET_SEED(16'hACE1)) dut_st2 (
        .clk(clk), .reset(reset), .load(load), .seed(seed), .en(en),
        .state(st2), .out_bit(ob2), .seed_zero(sz2), .wrap(wr2), .period(pr2));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] m_advance(input logic [15:0] s, input int mode, input int steps);
        int v;
        int fb;
        v = int'(s);
        for (int k = 0; k < steps; k++) begin
            if (mode == 0) begin
                v = (v / 2) ^ (((v % 2) == 1) ? 32'hB400 : 32'h0);
            end else begin
                fb = $countones(v & 32'hB400) % 2;
                v  = (v / 2) + fb * 32768;
            end
        end
        return v[15:0];
    endfunction

    task automatic model_update();
        logic [15:0] n;
        for (int i = 0; i < 3; i++) begin
            if (reset) begin
                m_st[i] = 16'hACE1; m_ref[i] = 16'hACE1;
                m_sz[i] = 1'b0; m_wr[i] = 1'b0; m_per[i] = 32'd0; m_adv[i] = 32'd0;
            end else if (load) begin
                m_st[i]  = (seed == 16'h0) ? 16'hACE1 : seed;
                m_ref[i] = m_st[i];
                m_sz[i]  = (seed == 16'h0);
                m_wr[i]  = 1'b0;
                m_adv[i] = 32'd0;
            end else if (en) begin
                n = m_advance(m_st[i], m_mode[i], m_steps[i]);
                m_st[i] = n;
                m_sz[i] = 1'b0;
                if (n == m_ref[i]) begin
                    m_wr[i]  = 1'b1;
                    m_per[i] = m_adv[i] + 32'd1;
                    m_adv[i] = 32'd0;
                end else begin
                    m_wr[i]  = 1'b0;
                    m_adv[i] = m_adv[i] + 32'd1;
                end
            end else begin
                m_sz[i] = 1'b0;
                m_wr[i] = 1'b0;
            end
        end
    endtask

    task automatic check_all();
        logic [15:0] s; logic o, z, w; logic [31:0] p, pexp;
        for (int i = 0; i < 3; i++) begin
            case (i)
                0: begin s = st0; o = ob0; z = sz0; w = wr0; p = pr0; end
                1: begin s = st1; o = ob1; z = sz1; w = wr1; p = pr1; end
                default: begin s = st2; o = ob2; z = sz2; w = wr2; p = pr2; end
            endcase
`ifdef LFSR_PERIOD_CNT_EN
            pexp = m_per[i];
`else
            pexp = 32'd0;
`endif
            chk($sformatf("state%0d", i), {16'h0, s}, {16'h0, m_st[i]});
            chk($sformatf("out_bit%0d", i), {31'h0, o}, {31'h0, m_st[i][0]});
            chk($sformatf("seed_zero%0d", i), {31'h0, z}, {31'h0, m_sz[i]});
            chk($sformatf("wrap%0d", i), {31'h0, w}, {31'h0, m_wr[i]});
            chk($sformatf("period%0d", i), p, pexp);
        end
    endtask

    task automatic cycle(input logic r, input logic l, input logic e, input logic [15:0] s);
        reset = r; load = l; en = e; seed = s;
        @(posedge clk);
        model_update();
        #1;
        check_all();
    endtask

    initial begin
        logic [31:0] exp_period;
        reset = 1'b1; load = 1'b0; en = 1'b0; seed = 16'h0;

        cycle(1'b1, 1'b0, 1'b0, 16'h0);
        cycle(1'b1, 1'b1, 1'b1, 16'h0);
        chk("rst_state", {16'h0, st0}, 32'h0000ACE1);
        chk("rst_out_bit", {31'h0, ob0}, 32'd1);
        chk("rst_period", pr0, 32'd0);

        // Galois and STEPS=2 from seed 0x0001
        cycle(1'b0, 1'b1, 1'b0, 16'h0001);
        cycle(1'b0, 1'b0, 1'b1, 16'h0);
        chk("gal_step1", {16'h0, st0}, 32'h0000B400);
        chk("st2_step1", {16'h0, st2}, 32'h00005A00);
        cycle(1'b0, 1'b0, 1'b1, 16'h0);
        chk("gal_step2", {16'h0, st0}, 32'h00005A00);

        // Fibonacci from 0x8000
        cycle(1'b0, 1'b1, 1'b0, 16'h8000);
        cycle(1'b0, 1'b0, 1'b1, 16'h0);
        chk("fib_step1", {16'h0, st1}, 32'h0000C000);

        // zero seed with en in the same cycle: substitute, no advance
        cycle(1'b0, 1'b1, 1'b1, 16'h0000);
        chk("zero_load_state", {16'h0, st0}, 32'h0000ACE1);
        chk("zero_load_pulse", {31'h0, sz0}, 32'd1);
        cycle(1'b0, 1'b0, 1'b0, 16'h0);
        chk("zero_pulse_end", {31'h0, sz0}, 32'd0);
        cycle(1'b0, 1'b1, 1'b1, 16'h1234);
        chk("load_en_state", {16'h0, st0}, 32'h00001234);
        cycle(1'b0, 1'b0, 1'b1, 16'h0);

        // random mix of load/en/hold with occasional reset and zero seeds
        for (int n = 0; n < 400; n++) begin
            logic r, l, e; logic [15:0] s;
            r = ($urandom_range(63) == 0);
            l = ($urandom_range(15) == 0);
            e = ($urandom_range(3) != 0);
            s = ($urandom_range(3) == 0) ? 16'h0 : 16'($urandom);
            cycle(r, l, e, s);
        end

        // reset mid-sequence outranks load and en
        cycle(1'b0, 1'b0, 1'b1, 16'h0);
        cycle(1'b1, 1'b1, 1'b1, 16'h5555);
        chk("mid_rst_state", {16'h0, st0}, 32'h0000ACE1);

        // full Galois period from seed 0x0001
        cycle(1'b0, 1'b1, 1'b0, 16'h0001);
        for (int n = 0; n < 65535; n++) begin
            cycle(1'b0, 1'b0, 1'b1, 16'h0);
            wraps += int'(wr0);
        end
`ifdef LFSR_PERIOD_CNT_EN
        exp_period = 32'd65535;
`else
        exp_period = 32'd0;
`endif
        chk("full_state", {16'h0, st0}, 32'h00000001);
        chk("full_wrap", {31'h0, wr0}, 32'd1);
        chk("full_wrap_count", wraps, 32'd1);
        chk("full_period", pr0, exp_period);
        cycle(1'b0, 1'b0, 1'b0, 16'h0);
        chk("wrap_pulse_end", {31'h0, wr0}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
